// File: rtl/coarse_gain_pkg.sv
// Shared definitions for the coarse gain stage: ramp FSM states, clamp
// constants and the divider width helper.
package coarse_gain_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_e;

  // Largest positive two's complement value for a w-bit sample
  function automatic logic [63:0] clamp_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value for a w-bit sample (bit pattern)
  function automatic logic [63:0] clamp_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // Ceiling log2, used to size the ramp divider
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (longint unsigned v = 1; v < longint'(n); v = v << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/coarse_gain_sat_shifter.sv
// One-channel combinational power-of-two shifter.
// With COARSE_GAIN_SAT_EN defined the result clamps on overflow and the
// overflow flag is reported; otherwise the result wraps and the flag is 0.
module sat_shifter
  import coarse_gain_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               ovf_o
);

`ifdef COARSE_GAIN_SAT_EN
  localparam int unsigned    MAX_SHIFT = (1 << SHIFT_W) - 1;
  localparam int unsigned    EXT_W     = WIDTH + MAX_SHIFT;
  localparam logic [WIDTH-1:0] POS_MAX = WIDTH'(clamp_max(WIDTH));
  localparam logic [WIDTH-1:0] NEG_MIN = WIDTH'(clamp_min(WIDTH));

  logic             sign;
  logic             ovf;
  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] shifted;

  // Shift a sign-extended copy; any upper bit differing from the sign means overflow
  always_comb begin
    sign    = data_i[WIDTH-1];
    ext     = {{MAX_SHIFT{sign}}, data_i};
    shifted = ext << shift_i;
    ovf     = (shifted[EXT_W-1:WIDTH-1] != {(MAX_SHIFT + 1){sign}});
    data_o  = ovf ? (sign ? NEG_MIN : POS_MAX) : shifted[WIDTH-1:0];
    ovf_o   = ovf;
  end
`else
  // Plain wrap-around shift
  always_comb begin
    data_o = data_i << shift_i;
    ovf_o  = 1'b0;
  end
`endif

endmodule

// File: rtl/coarse_gain_stage.sv
// Multi-channel pipelined coarse gain stage with ramped shift changes.
// Optional saturation and sticky sat_o flags are enabled by COARSE_GAIN_SAT_EN.
module coarse_gain_stage
  import coarse_gain_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SHIFT_W  = 3,
  parameter int unsigned RAMP_DIV = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic                      valid_i,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic                      valid_o,
  input  logic [SHIFT_W-1:0]        shift_i,
  input  logic                      shift_we_i,
  output logic [SHIFT_W-1:0]        shift_cur_o,
  output logic                      shift_busy_o,
  output logic [CHANNELS-1:0]       sat_o,
  input  logic                      sat_clr_i
);

  localparam int unsigned      DIV_W    = (clog2(RAMP_DIV) < 1) ? 1 : clog2(RAMP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  ramp_state_e               state_q, state_d;
  logic [SHIFT_W-1:0]        target_q, target_d;
  logic [SHIFT_W-1:0]        shift_cur_q, shift_cur_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic                      busy_q, busy_d;

  logic [CHANNELS*WIDTH-1:0] s1_data_q, s1_data_d;
  logic [SHIFT_W-1:0]        s1_shift_q, s1_shift_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;

  logic [CHANNELS*WIDTH-1:0] shifted;
  logic [CHANNELS-1:0]       ovf;

  // Ramp FSM: walk shift_cur one step per RAMP_DIV cycles toward the target.
  // A retarget uses the new value immediately, so the step direction and the
  // completion test both look at target_d rather than target_q.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    div_d       = div_q;
    shift_cur_d = shift_cur_q;
    case (state_q)
      ST_IDLE: begin
        if (shift_we_i && (shift_i != shift_cur_q)) begin
          target_d = shift_i;
          div_d    = '0;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (shift_we_i) begin
          target_d = shift_i;
        end
        if (target_d == shift_cur_q) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d       = '0;
          shift_cur_d = (target_d > shift_cur_q) ? shift_cur_q + SHIFT_W'(1)
                                                 : shift_cur_q - SHIFT_W'(1);
          if (shift_cur_d == target_d) begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RAMP);
  end

  // Two-stage datapath: capture sample with its shift, then register the scaled result
  always_comb begin
    s1_valid_d  = valid_i;
    s1_data_d   = valid_i ? data_i : s1_data_q;
    s1_shift_d  = valid_i ? shift_cur_q : s1_shift_q;
    out_valid_d = s1_valid_q;
    out_data_d  = s1_valid_q ? shifted : out_data_q;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    sat_shifter #(
      .WIDTH  (WIDTH),
      .SHIFT_W(SHIFT_W)
    ) u_shift (
      .data_i (s1_data_q[k*WIDTH +: WIDTH]),
      .shift_i(s1_shift_q),
      .data_o (shifted[k*WIDTH +: WIDTH]),
      .ovf_o  (ovf[k])
    );
  end

  // State and pipeline registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      shift_cur_q <= '0;
      div_q       <= '0;
      busy_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_shift_q  <= '0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      shift_cur_q <= shift_cur_d;
      div_q       <= div_d;
      busy_q      <= busy_d;
      s1_data_q   <= s1_data_d;
      s1_shift_q  <= s1_shift_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef COARSE_GAIN_SAT_EN
  logic [CHANNELS-1:0] sat_q, sat_d;

  // Sticky flags; a new clamp in the same cycle as a clear keeps the flag set
  always_comb begin
    sat_d = (sat_clr_i ? '0 : sat_q) | (s1_valid_q ? ovf : '0);
  end

  // Saturation flag register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  logic sat_unused;
  assign sat_unused = sat_clr_i | (|ovf);
  assign sat_o      = '0;
`endif

  assign data_o       = out_data_q;
  assign valid_o      = out_valid_q;
  assign shift_cur_o  = shift_cur_q;
  assign shift_busy_o = busy_q;

endmodule

// File: tb/tb_coarse_gain_stage.sv
// Self-checking bench for coarse_gain_stage (RAMP_DIV=4) with a
// arithmetic reference model for scaling and ramp timing.
module tb_coarse_gain_stage;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned SHIFT_W  = 3;
  localparam int unsigned RAMP_DIV = 4;
  localparam int          WAIT_MAX = 200;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic [2:0]  shift_i = '0;
  logic        shift_we_i = 1'b0;
  logic [2:0]  shift_cur_o;
  logic        shift_busy_o;
  logic [1:0]  sat_o;
  logic        sat_clr_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  coarse_gain_stage #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .SHIFT_W (SHIFT_W),
    .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .shift_i     (shift_i),
    .shift_we_i  (shift_we_i),
    .shift_cur_o (shift_cur_o),
    .shift_busy_o(shift_busy_o),
    .sat_o       (sat_o),
    .sat_clr_i   (sat_clr_i)
  );

  always #5 clk = ~clk;

  // Reference: multiply by 2^s, then clamp or wrap to 16 bits
  function automatic logic [15:0] ref_scale(input logic [15:0] d, input int s, output bit ovf);
    longint v;
    v   = longint'($signed(d)) * (longint'(1) << s);
    ovf = (v > 32767) || (v < -32768);
`ifdef COARSE_GAIN_SAT_EN
    if (ovf) return (v > 0) ? 16'h7FFF : 16'h8000;
`else
    ovf = 1'b0;
`endif
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid_i   = 1'b0;
    sat_clr_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_shift(input int s);
    int n;
    if (int'(shift_cur_o) != s) begin
      shift_i    = 3'(s);
      shift_we_i = 1'b1;
      tick();
      shift_we_i = 1'b0;
      n = 0;
      while (shift_busy_o && n < WAIT_MAX) begin
        tick();
        n++;
      end
      vectors++;
      if (shift_busy_o) begin
        miscompares++;
        $display("FAIL set_shift_timeout: busy=%0d after %0d cycles, required 0", shift_busy_o, n);
      end
    end
    vectors++;
    if (int'(shift_cur_o) !== s) begin
      miscompares++;
      $display("FAIL set_shift_value: shift_cur=%0d required %0d", shift_cur_o, s);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (data_o !== 32'h0 || valid_o !== 1'b0 || shift_cur_o !== 3'd0 ||
        shift_busy_o !== 1'b0 || sat_o !== 2'b00) begin
      miscompares++;
      $display("FAIL %s: data=%h valid=%b cur=%0d busy=%b sat=%b required all zero",
               tag, data_o, valid_o, shift_cur_o, shift_busy_o, sat_o);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    check_all_zero("reset_hold");
    #2 rstn_i = 1'b1;
    tick();
    check_all_zero("reset_release");
  endtask

  task automatic test_basic_shift();
    set_shift(3);
    drain();
    data_i    = {16'hFFFE, 16'h0123};
    valid_i   = 1'b1;
    sat_clr_i = 1'b1;
    tick();
    valid_i   = 1'b0;
    sat_clr_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: valid_o=%b one cycle after input, required 0", valid_o);
    end
    tick();
    vectors++;
    if (data_o !== 32'hFFF0_0918) begin
      miscompares++;
      $display("FAIL basic_data: got %h required %h", data_o, 32'hFFF0_0918);
    end
    vectors++;
    if (valid_o !== 1'b1 || sat_o !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_flags: valid=%b sat=%b required 1 / 00", valid_o, sat_o);
    end
    tick();
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 32'hFFF0_0918) begin
      miscompares++;
      $display("FAIL basic_hold: valid=%b data=%h required 0 / fff00918", valid_o, data_o);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_d;
    logic [1:0]  exp_s;
    set_shift(3);
    drain();
    data_i  = {16'hF000, 16'h1000};
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
`ifdef COARSE_GAIN_SAT_EN
    exp_d = 32'h8000_7FFF;
    exp_s = 2'b01;  // -4096*8 = -32768 fits exactly, so only ch0 clamps
`else
    exp_d = 32'h8000_8000;
    exp_s = 2'b00;
`endif
    vectors++;
    if (data_o !== exp_d) begin
      miscompares++;
      $display("FAIL sat_data: got %h required %h", data_o, exp_d);
    end
    vectors++;
    if (sat_o !== exp_s) begin
      miscompares++;
      $display("FAIL sat_flags: got %b required %b", sat_o, exp_s);
    end
    tick();
    vectors++;
    if (sat_o !== exp_s) begin
      miscompares++;
      $display("FAIL sat_sticky: got %b required %b", sat_o, exp_s);
    end
    data_i    = {16'h0001, 16'h0001};
    valid_i   = 1'b1;
    sat_clr_i = 1'b1;
    tick();
    valid_i   = 1'b0;
    sat_clr_i = 1'b0;
    tick();
    vectors++;
    if (sat_o !== 2'b00 || data_o !== 32'h0008_0008) begin
      miscompares++;
      $display("FAIL sat_clear: sat=%b data=%h required 00 / 00080008", sat_o, data_o);
    end
  endtask

  task automatic test_random_datapath();
    for (int r = 0; r < 4; r++) begin
      int          s;
      bit          pv;
      logic [31:0] pd;
      logic [31:0] hold;
      bit          have_hold;
      logic [1:0]  sat_m;
      s = (r == 0) ? 7 : int'($urandom_range(0, 7));
      set_shift(s);
      drain();
      pv = 1'b0; pd = '0; hold = '0; have_hold = 1'b0; sat_m = '0;
      for (int i = 0; i < 40; i++) begin
        logic [31:0] d;
        bit          v;
        bit          c;
        for (int k = 0; k < 2; k++) begin
          if ($urandom_range(0, 2) == 0) d[k*16 +: 16] = 16'($urandom);
          else d[k*16 +: 16] = 16'(int'($urandom_range(0, 64)) - 32);
        end
        v = ($urandom_range(0, 3) != 0);
        c = (i == 0) || ($urandom_range(0, 7) == 0);
        data_i    = d;
        valid_i   = v;
        sat_clr_i = c;
        tick();
        if (c) sat_m = '0;
        if (pv) begin
          for (int k = 0; k < 2; k++) begin
            bit ov;
            hold[k*16 +: 16] = ref_scale(pd[k*16 +: 16], s, ov);
            if (ov) sat_m[k] = 1'b1;
          end
          have_hold = 1'b1;
        end
        vectors++;
        if (valid_o !== pv) begin
          miscompares++;
          $display("FAIL rand_valid: shift=%0d i=%0d got %b required %b", s, i, valid_o, pv);
        end
        if (have_hold) begin
          vectors++;
          if (data_o !== hold) begin
            miscompares++;
            $display("FAIL rand_data: shift=%0d i=%0d in=%h got %h required %h", s, i, pd, data_o, hold);
          end
        end
        vectors++;
        if (sat_o !== sat_m) begin
          miscompares++;
          $display("FAIL rand_sat: shift=%0d i=%0d got %b required %b", s, i, sat_o, sat_m);
        end
        pv = v;
        pd = d;
      end
      valid_i   = 1'b0;
      sat_clr_i = 1'b0;
    end
  endtask

  // Ramp from 'from' to 'to': cur after k cycles moves floor(k/RAMP_DIV) steps, capped at target
  task automatic test_ramp(input int from, input int to, input string tag);
    int steps;
    steps = (to > from) ? to - from : from - to;
    set_shift(from);
    shift_i    = 3'(to);
    shift_we_i = 1'b1;
    tick();
    shift_we_i = 1'b0;
    for (int k = 0; k <= steps * int'(RAMP_DIV) + 4; k++) begin
      int mv;
      int exp_cur;
      bit exp_busy;
      if (k > 0) tick();
      mv       = k / int'(RAMP_DIV);
      if (mv > steps) mv = steps;
      exp_cur  = (to > from) ? from + mv : from - mv;
      exp_busy = (k < steps * int'(RAMP_DIV));
      vectors++;
      if (int'(shift_cur_o) !== exp_cur || shift_busy_o !== exp_busy) begin
        miscompares++;
        $display("FAIL %s: k=%0d cur=%0d busy=%b required %0d / %b",
                 tag, k, shift_cur_o, shift_busy_o, exp_cur, exp_busy);
      end
    end
  endtask

  task automatic test_retarget();
    set_shift(0);
    shift_i    = 3'd6;
    shift_we_i = 1'b1;
    tick();
    shift_we_i = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      int exp_cur;
      bit exp_busy;
      if (k > 0) tick();
      shift_we_i = 1'b0;
      exp_cur  = (k < 12) ? k / 4 : 1;
      exp_busy = (k < 12);
      vectors++;
      if (int'(shift_cur_o) !== exp_cur || shift_busy_o !== exp_busy) begin
        miscompares++;
        $display("FAIL retarget: k=%0d cur=%0d busy=%b required %0d / %b",
                 k, shift_cur_o, shift_busy_o, exp_cur, exp_busy);
      end
      if (k == 8) begin
        shift_i    = 3'd1;
        shift_we_i = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic [31:0] d;
    set_shift(0);
    shift_i    = 3'd5;
    shift_we_i = 1'b1;
    tick();
    shift_we_i = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      data_i  = $urandom;
      valid_i = 1'b1;
      tick();
    end
    vectors++;
    if (shift_cur_o !== 3'd3 || shift_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state: cur=%0d busy=%b required 3 / 1", shift_cur_o, shift_busy_o);
    end
    #2 rstn_i = 1'b0;
    #1 check_all_zero("async_reset");
    valid_i = 1'b0;
    tick();
    #2 rstn_i = 1'b1;
    tick();
    vectors++;
    if (shift_cur_o !== 3'd0 || shift_busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: cur=%0d busy=%b required 0 / 0", shift_cur_o, shift_busy_o);
    end
    d       = {16'h8001, 16'h1234};
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    vectors++;
    if (data_o !== d || valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_unscaled: data=%h valid=%b required %h / 1", data_o, valid_o, d);
    end
    for (int k = 0; k < 6; k++) tick();
    vectors++;
    if (shift_cur_o !== 3'd0 || shift_busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_stays_idle: cur=%0d busy=%b required 0 / 0", shift_cur_o, shift_busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_shift();
    test_saturation();
    test_random_datapath();
    test_ramp(0, 5, "ramp_up");
    test_ramp(5, 2, "ramp_down");
    test_retarget();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
